// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer: free-running cycle counter, compare register and a level
// interrupt held until acked. Optional period auto-reload when TIMER_AUTORELOAD_EN is defined.
module timer_irq_source #(
  parameter logic [31:0] CYCLE_ADDR  = 32'hFFFF001C,
  parameter logic [31:0] ACK_ADDR    = 32'hFFFF006C,
  parameter logic [31:0] PERIOD_ADDR = 32'hFFFF0070
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rd_data,
  output logic        TimerAddress,
  output logic        TimerInterrupt
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        hit_cycle, hit_ack, hit_period;
  logic        match, wr_compare, wr_ack;

  assign hit_cycle  = (address == CYCLE_ADDR);
  assign hit_ack    = (address == ACK_ADDR);
  assign wr_compare = MemWrite && hit_cycle;
  assign wr_ack     = MemWrite && hit_ack;
  assign match      = (cycle_q == compare_q);

`ifdef TIMER_AUTORELOAD_EN
  logic [31:0] period_q, period_d;
  logic        wr_period;

  assign hit_period = (address == PERIOD_ADDR);
  assign wr_period  = MemWrite && hit_period;

  always_comb begin
    period_d = period_q;
    if (wr_period) period_d = wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) period_q <= 32'd0;
    else       period_q <= period_d;
  end
`else
  // Period address is left undecoded in this build.
  logic unused_period_addr;
  assign unused_period_addr = ^PERIOD_ADDR;
  assign hit_period = 1'b0;
`endif

  assign TimerAddress   = hit_cycle || hit_ack || hit_period;
  assign TimerInterrupt = pending_q;

  always_comb begin
    rd_data = 32'd0;
    if (MemRead) begin
      if (hit_cycle)    rd_data = cycle_q;
      else if (hit_ack) rd_data = {30'd0, overrun_q, pending_q};
`ifdef TIMER_AUTORELOAD_EN
      else if (hit_period) rd_data = period_q;
`endif
    end
  end

  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    compare_d = compare_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    // A software compare store beats the automatic reload.
    if (wr_compare) compare_d = wr_data;
`ifdef TIMER_AUTORELOAD_EN
    else if (match && (period_q != 32'd0)) compare_d = compare_q + period_q;
`endif

    // Ack clears both flags; a coincident match re-sets pending but leaves overrun clear.
    if (wr_ack) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end else if (match && pending_q) begin
      overrun_d = 1'b1;
    end
    if (match) pending_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q   <= 32'd0;
      compare_q <= 32'hFFFFFFFF;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Bench for timer_irq_source: directed timing scenarios plus randomized bus traffic
// checked against a rule-level reference model.
module tb_timer_irq_source;

  localparam logic [31:0] CYC  = 32'hFFFF001C;
  localparam logic [31:0] ACK  = 32'hFFFF006C;
  localparam logic [31:0] PER  = 32'hFFFF0070;
  localparam logic [31:0] DMEM = 32'h10010000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rd_data;
  logic        TimerAddress;
  logic        TimerInterrupt;

  int n_checks = 0;
  int n_fail   = 0;

  timer_irq_source dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .wr_data       (wr_data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .rd_data       (rd_data),
    .TimerAddress  (TimerAddress),
    .TimerInterrupt(TimerInterrupt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural state updated from the bus strobes seen at each edge.
  logic [31:0] m_cycle, m_compare, m_period;
  logic        m_pending, m_overrun;

  always @(posedge clock) begin
    if (reset) begin
      m_cycle   <= 32'd0;
      m_compare <= 32'hFFFFFFFF;
      m_period  <= 32'd0;
      m_pending <= 1'b0;
      m_overrun <= 1'b0;
    end else begin
      m_cycle <= m_cycle + 32'd1;
      if (MemWrite && address == CYC) m_compare <= wr_data;
`ifdef TIMER_AUTORELOAD_EN
      else if (m_cycle == m_compare && m_period != 0) m_compare <= m_compare + m_period;
      if (MemWrite && address == PER) m_period <= wr_data;
`endif
      if (m_cycle == m_compare) m_pending <= 1'b1;
      else if (MemWrite && address == ACK) m_pending <= 1'b0;
      if (MemWrite && address == ACK) m_overrun <= 1'b0;
      else if (m_cycle == m_compare && m_pending) m_overrun <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == CYC) return m_cycle;
    if (a == ACK) return {30'd0, m_overrun, m_pending};
`ifdef TIMER_AUTORELOAD_EN
    if (a == PER) return m_period;
`endif
    return 32'd0;
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
`ifdef TIMER_AUTORELOAD_EN
    return (a == CYC) || (a == ACK) || (a == PER);
`else
    return (a == CYC) || (a == ACK);
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    address  = a;
    wr_data  = d;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    address  = DMEM;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic rd);
    address = a;
    MemRead = rd;
    #1;
    check({tag, ".rd"}, rd_data, rd ? exp_rd(a) : 32'd0);
    check({tag, ".hit"}, {31'd0, TimerAddress}, {31'd0, exp_hit(a)});
    MemRead = 1'b0;
    address = DMEM;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    address = ACK;
    MemRead = 1'b1;
    #1;
    check(tag, rd_data, exp);
    MemRead = 1'b0;
    address = DMEM;
  endtask

  logic [31:0] c;
  logic [31:0] fired[$];
  int          op;
  logic [31:0] ra;

  initial begin
    reset = 1'b1; address = DMEM; wr_data = 32'd0; MemRead = 1'b0; MemWrite = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_irq", {31'd0, TimerInterrupt}, 32'd0);
    read_status("rst_status", 32'd0);

    repeat (10) tick();
    address = CYC; MemRead = 1'b1; #1;
    check("cycle10", rd_data, 32'd10);
    check("hit_cyc", {31'd0, TimerAddress}, 32'd1);
    address = DMEM; #1;
    check("hit_dmem", {31'd0, TimerAddress}, 32'd0);
    check("rd_dmem", rd_data, 32'd0);
    MemRead = 1'b0;
    check("idle_irq", {31'd0, TimerInterrupt}, 32'd0);

    // Compare = cycle+5: interrupt rises exactly five edges after the store edge.
    c = m_cycle;
    store(CYC, c + 32'd5);
    check("cmp_e0", {31'd0, TimerInterrupt}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check((i < 5) ? "cmp_low" : "cmp_rise", {31'd0, TimerInterrupt}, (i < 5) ? 32'd0 : 32'd1);
    end
    store(ACK, $urandom);
    check("ack_irq", {31'd0, TimerInterrupt}, 32'd0);
    read_status("ack_status", 32'd0);

    // Two matches without an ack in between set overrun.
    c = m_cycle; store(CYC, c + 32'd3); repeat (3) tick();
    check("ovr_first", {31'd0, TimerInterrupt}, 32'd1);
    c = m_cycle; store(CYC, c + 32'd3); repeat (3) tick();
    read_status("ovr_status", 32'd3);
    store(ACK, 32'd0);
    read_status("ovr_cleared", 32'd0);
    check("ovr_irq", {31'd0, TimerInterrupt}, 32'd0);

    // Ack landing on the same edge as a match, with pending already set.
    c = m_cycle; store(CYC, c + 32'd3); repeat (3) tick();
    c = m_cycle; store(CYC, c + 32'd3); tick(); tick();
    store(ACK, 32'hDEADBEEF);
    check("same_irq", {31'd0, TimerInterrupt}, 32'd1);
    read_status("same_status", 32'd1);
    store(ACK, 32'd0);

`ifdef TIMER_AUTORELOAD_EN
    reset = 1'b1; tick(); reset = 1'b0;
    store(PER, 32'd100);
    store(CYC, 32'd50);
    fired.delete();
    while (m_cycle < 32'd300) begin
      tick();
      if (TimerInterrupt) begin
        fired.push_back(m_cycle - 32'd1);
        store(ACK, 32'd0);
      end
    end
    check("ar_count", fired.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check("ar_at", (i < fired.size()) ? fired[i] : 32'hFFFFFFFF, 32'd50 + 32'(i) * 32'd100);
    load_check("ar_per", PER, 1'b1);
    check("ar_per_val", exp_rd(PER), 32'd100);
`else
    address = PER; MemRead = 1'b1; #1;
    check("per_rd", rd_data, 32'd0);
    check("per_hit", {31'd0, TimerAddress}, 32'd0);
    MemRead = 1'b0;
    store(PER, 32'd100);
    load_check("per_after", PER, 1'b1);
`endif

    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 15);
      case (op)
        0, 1, 2, 3: store(CYC, m_cycle + $urandom_range(1, 12));
        4, 5:       store(ACK, $urandom);
        6:          store($urandom, $urandom);
        7:          store(PER, $urandom_range(0, 20));
        8: begin
          if ($urandom_range(0, 9) == 0) begin
            reset = 1'b1; address = CYC; wr_data = $urandom; MemWrite = 1'b1;
            tick();
            reset = 1'b0; MemWrite = 1'b0; address = DMEM;
          end else tick();
        end
        default:    tick();
      endcase
      check("rnd_irq", {31'd0, TimerInterrupt}, {31'd0, m_pending});
      case ($urandom_range(0, 3))
        0:       ra = CYC;
        1:       ra = ACK;
        2:       ra = PER;
        default: ra = $urandom;
      endcase
      load_check("rnd_load", ra, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
